// File: rtl/pad_arb_pkg.sv
// rtl/pad_arb_pkg.sv - shared types, counter widths and saturating cursor math
package pad_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    localparam int DEF_REPEAT_FRAMES = 8;
    localparam int DEF_HOLD_FRAMES   = 60;

    // Repeat counter tops out at REPEAT_FRAMES-1; idle counter reaches HOLD_FRAMES.
    function automatic int rep_cnt_w(input int repeat_frames);
        return $clog2(repeat_frames);
    endfunction

    function automatic int hold_cnt_w(input int hold_frames);
        return $clog2(hold_frames + 1);
    endfunction

    localparam int REPEAT_CNT_W = rep_cnt_w(DEF_REPEAT_FRAMES);
    localparam int HOLD_CNT_W   = hold_cnt_w(DEF_HOLD_FRAMES);

    function automatic logic [9:0] sat_inc(input logic [9:0] pos, input int step, input int max);
        logic [10:0] sum;
        sum = {1'b0, pos} + 11'(step);
        if (sum > 11'(max)) begin
            sum = 11'(max);
        end
        return sum[9:0];
    endfunction

    function automatic logic [9:0] sat_dec(input logic [9:0] pos, input int step);
        logic [10:0] diff;
        if ({1'b0, pos} < 11'(step)) begin
            diff = 11'd0;
        end else begin
            diff = {1'b0, pos} - 11'(step);
        end
        return diff[9:0];
    endfunction

endpackage

// File: rtl/pad_cursor_arbiter_repeat_timer.sv
// rtl/pad_cursor_arbiter_repeat_timer.sv - per-axis press-edge step and auto-repeat timer
module pad_repeat_timer
    import pad_arb_pkg::*;
#(
    parameter int REPEAT_FRAMES = DEF_REPEAT_FRAMES
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic clear,
    input  logic neg,
    input  logic pos,
    input  logic prev_neg,
    input  logic prev_pos,
    output logic step_neg,
    output logic step_pos
);

    localparam int W = rep_cnt_w(REPEAT_FRAMES);
    localparam logic [W-1:0] LAST = W'(REPEAT_FRAMES - 1);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_next;
    logic         fire;

    always_comb begin
        cnt_next = cnt;
        fire     = 1'b0;
        if (clear) begin
            cnt_next = '0;
        end else if (tick) begin
            if (neg && pos) begin
                cnt_next = '0;
            end else if (neg || pos) begin
                if ((neg && !prev_neg) || (pos && !prev_pos)) begin
                    fire     = 1'b1;
                    cnt_next = '0;
                end else if (cnt == LAST) begin
                    fire     = 1'b1;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end else begin
                cnt_next = '0;
            end
        end
    end

    assign step_neg = fire & neg;
    assign step_pos = fire & pos;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/pad_cursor_arbiter.sv
// rtl/pad_cursor_arbiter.sv - frame-synchronous two-pad cursor ownership arbiter
module pad_cursor_arbiter
    import pad_arb_pkg::*;
#(
    parameter int X_MAX         = 639,
    parameter int Y_MAX         = 479,
    parameter int STEP          = 4,
    parameter int REPEAT_FRAMES = DEF_REPEAT_FRAMES,
    parameter int HOLD_FRAMES   = DEF_HOLD_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [1:0] up,
    input  logic [1:0] down,
    input  logic [1:0] left,
    input  logic [1:0] right,
    input  logic [1:0] a,
    input  logic [1:0] is_present,
    output logic [9:0] cursor_x,
    output logic [9:0] cursor_y,
    output logic       owner,
    output logic       owner_valid,
    output logic       select_pulse
);

    localparam int HW = hold_cnt_w(HOLD_FRAMES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    arb_state_e      state;
    logic            last_owner;
    logic [HW-1:0]   idle_cnt;
    logic [1:0][4:0] btn;
    logic [1:0][4:0] prev;
    logic [4:0]      own_btn;
    logic [4:0]      own_prev;
    logic [1:0]      req;
    logic            move_tick;
    logic            idle_tick;
    logic            x_neg, x_pos, y_neg, y_pos;

    // Button vector layout: {a, right, left, down, up}.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            btn[i] = {a[i], right[i], left[i], down[i], up[i]};
            req[i] = is_present[i] & (|btn[i]);
        end
    end

    assign own_btn   = btn[owner];
    assign own_prev  = prev[owner];
    assign move_tick = frame_tick && (state == OWNED) && is_present[owner] && (|own_btn);
    assign idle_tick = frame_tick && (state == IDLE);

    pad_repeat_timer #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_timer_x (
        .clk      (clk),
        .reset    (reset),
        .tick     (move_tick),
        .clear    (idle_tick),
        .neg      (own_btn[2]),
        .pos      (own_btn[3]),
        .prev_neg (own_prev[2]),
        .prev_pos (own_prev[3]),
        .step_neg (x_neg),
        .step_pos (x_pos)
    );

    pad_repeat_timer #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_timer_y (
        .clk      (clk),
        .reset    (reset),
        .tick     (move_tick),
        .clear    (idle_tick),
        .neg      (own_btn[0]),
        .pos      (own_btn[1]),
        .prev_neg (own_prev[0]),
        .prev_pos (own_prev[1]),
        .step_neg (y_neg),
        .step_pos (y_pos)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= 1'b0;
            owner_valid  <= 1'b0;
            last_owner   <= 1'b1;
            idle_cnt     <= '0;
            prev         <= '0;
            cursor_x     <= 10'(X_MAX >> 1);
            cursor_y     <= 10'(Y_MAX >> 1);
            select_pulse <= 1'b0;
        end else begin
            select_pulse <= 1'b0;
            if (frame_tick) begin
                prev <= btn;
                case (state)
                    IDLE: begin
                        if (|req) begin
                            state       <= OWNED;
                            owner_valid <= 1'b1;
                            idle_cnt    <= '0;
                            owner       <= (&req) ? ~last_owner : req[1];
                        end
                    end
                    OWNED: begin
                        if (!is_present[owner]) begin
                            state       <= IDLE;
                            owner_valid <= 1'b0;
                            last_owner  <= owner;
                        end else if (|own_btn) begin
                            idle_cnt     <= '0;
                            select_pulse <= own_btn[4] & ~own_prev[4];
                            if (x_pos) begin
                                cursor_x <= sat_inc(cursor_x, STEP, X_MAX);
                            end else if (x_neg) begin
                                cursor_x <= sat_dec(cursor_x, STEP);
                            end
                            if (y_pos) begin
                                cursor_y <= sat_inc(cursor_y, STEP, Y_MAX);
                            end else if (y_neg) begin
                                cursor_y <= sat_dec(cursor_y, STEP);
                            end
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                            if (idle_cnt == HOLD_LAST) begin
                                state       <= IDLE;
                                owner_valid <= 1'b0;
                                last_owner  <= owner;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pad_cursor_arbiter.sv
// tb/tb_pad_cursor_arbiter.sv - scoreboard bench for pad_cursor_arbiter
module tb_pad_cursor_arbiter;

    localparam int X_MAX = 639, Y_MAX = 479, STEP = 4, REP = 8, HOLD = 60;
    localparam logic [4:0] B_UP = 5'd1, B_DN = 5'd2, B_LF = 5'd4, B_RT = 5'd8, B_A = 5'd16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [1:0] up = '0, down = '0, left = '0, right = '0, a = '0, is_present = '0;
    logic [9:0] cursor_x, cursor_y;
    logic       owner, owner_valid, select_pulse;

    pad_cursor_arbiter #(
        .X_MAX(X_MAX), .Y_MAX(Y_MAX), .STEP(STEP), .REPEAT_FRAMES(REP), .HOLD_FRAMES(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .up(up), .down(down), .left(left), .right(right), .a(a),
        .is_present(is_present),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .owner(owner), .owner_valid(owner_valid), .select_pulse(select_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit ov;
        bit own;
        bit sel;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    int         mx, my, m_idle;
    int         since [2];
    bit         m_owned, m_owner, m_last;
    logic [4:0] m_prev [2];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        mx = X_MAX / 2;
        my = Y_MAX / 2;
        m_idle = 0;
        since[0] = 0;
        since[1] = 0;
        m_owned = 0;
        m_owner = 0;
        m_last = 1;
        m_prev[0] = '0;
        m_prev[1] = '0;
    endtask

    // Axis 0 is x (neg=left, pos=right), axis 1 is y (neg=up, pos=down).
    task automatic model_axis(input int ax, input bit n, input bit p, input bit pn, input bit pp);
        int d = 0;
        int lim = (ax == 0) ? X_MAX : Y_MAX;
        int v = (ax == 0) ? mx : my;
        if (n && p) begin
            since[ax] = 0;
        end else if (n || p) begin
            if (n ? !pn : !pp) begin
                d = p ? 1 : -1;
                since[ax] = 0;
            end else begin
                since[ax]++;
                if (since[ax] == REP) begin
                    d = p ? 1 : -1;
                    since[ax] = 0;
                end
            end
        end else begin
            since[ax] = 0;
        end
        if (d > 0) v = (v + STEP > lim) ? lim : v + STEP;
        if (d < 0) v = (v < STEP) ? 0 : v - STEP;
        if (ax == 0) mx = v; else my = v;
    endtask

    task automatic model_tick(input logic [4:0] b0, input logic [4:0] b1, input logic [1:0] pres);
        bit r0, r1, sel;
        logic [4:0] ob, op;
        exp_t e;
        sel = 0;
        if (!m_owned) begin
            since[0] = 0;
            since[1] = 0;
            r0 = pres[0] && (b0 != 0);
            r1 = pres[1] && (b1 != 0);
            if (r0 || r1) begin
                m_owner = (r0 && r1) ? !m_last : r1;
                m_owned = 1;
                m_idle = 0;
            end
        end else begin
            ob = m_owner ? b1 : b0;
            op = m_prev[m_owner];
            if (!pres[m_owner]) begin
                m_last = m_owner;
                m_owned = 0;
            end else if (ob != 0) begin
                m_idle = 0;
                model_axis(0, ob[2], ob[3], op[2], op[3]);
                model_axis(1, ob[0], ob[1], op[0], op[1]);
                sel = ob[4] && !op[4];
            end else begin
                m_idle++;
                if (m_idle >= HOLD) begin
                    m_last = m_owner;
                    m_owned = 0;
                end
            end
        end
        m_prev[0] = b0;
        m_prev[1] = b1;
        e.x = mx; e.y = my; e.ov = m_owned; e.own = m_owner; e.sel = sel;
        exp_q.push_back(e);
    endtask

    task automatic drive_btns(input logic [4:0] b0, input logic [4:0] b1);
        up    = {b1[0], b0[0]};
        down  = {b1[1], b0[1]};
        left  = {b1[2], b0[2]};
        right = {b1[3], b0[3]};
        a     = {b1[4], b0[4]};
    endtask

    // Called at posedge+1; inputs wander randomly between ticks to prove they are ignored.
    task automatic tick(input logic [4:0] b0, input logic [4:0] b1, input logic [1:0] pres, input int gap);
        drive_btns(b0, b1);
        is_present = pres;
        frame_tick = 1'b1;
        model_tick(b0, b1, pres);
        @(posedge clk); #1;
        frame_tick = 1'b0;
        for (int i = 0; i < gap; i++) begin
            drive_btns(5'($urandom), 5'($urandom));
            is_present = 2'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset(input string tag);
        @(negedge clk);
        chk({tag, "_x"}, cursor_x, 319);
        chk({tag, "_y"}, cursor_y, 239);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_valid"}, owner_valid, 0);
        chk({tag, "_sel"}, select_pulse, 0);
        @(posedge clk); #1;
    endtask

    logic post_tick = 1'b0;
    always @(posedge clk) post_tick <= frame_tick && !reset;

    always @(negedge clk) begin
        exp_t e;
        if (post_tick) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual=output expected=none t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("cursor_x", cursor_x, e.x);
                chk("cursor_y", cursor_y, e.y);
                chk("owner_valid", owner_valid, e.ov);
                chk("owner", owner, e.own);
                chk("select_pulse", select_pulse, e.sel);
            end
        end else if (!reset) begin
            chk("sel_quiet", select_pulse, 0);
        end
    end

    initial begin
        logic [4:0] rb [2];
        logic [1:0] rp;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset("rst");

        tick(B_A, B_A, 2'b11, 1);
        for (int i = 0; i < 10; i++) tick(B_RT, 5'd0, 2'b11, i % 2);
        for (int i = 0; i < 90; i++) tick((i % 2) ? 5'd0 : B_RT, 5'd0, 2'b11, 0);
        for (int i = 0; i < 70; i++) tick((i % 2) ? 5'd0 : B_UP, B_A, 2'b11, 0);
        for (int i = 0; i < 3; i++) tick(B_UP | B_DN, 5'd0, 2'b11, 1);
        for (int i = 0; i < HOLD; i++) tick(5'd0, 5'd0, 2'b11, 0);
        tick(B_A, B_A, 2'b11, 1);
        tick(B_DN | B_A, B_RT, 2'b11, 0);
        tick(B_RT, B_RT, 2'b01, 2);
        tick(B_LF, B_RT, 2'b11, 0);

        rb[0] = '0;
        rb[1] = '0;
        rp = 2'b11;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(9) < 3) rb[c] = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            end
            if ($urandom_range(39) == 0) rp = 2'($urandom);
            else if ($urandom_range(9) == 0) rp = 2'b11;
            tick(rb[0], rb[1], rp, $urandom_range(3));
        end

        tick(B_A, 5'd0, 2'b11, 0);
        tick(B_A | B_RT, 5'd0, 2'b11, 0);
        reset = 1'b1;
        frame_tick = 1'b1;
        drive_btns(B_A, B_A);
        @(posedge clk); #1;
        frame_tick = 1'b0;
        reset = 1'b0;
        model_reset();
        check_reset("tick_rst");

        repeat (3) @(posedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
